// File: rtl/dpram_sc_pkg.sv
// Shared defaults for the small single-clock RAM tables used across the decoder.
package dpram_sc_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 6;
  localparam int unsigned DEF_DTA_WIDTH  = 8;

endpackage

// File: rtl/dpram_sc.sv
// Single-clock simple dual-port RAM: one write port, one registered read port (read-first).
module dpram_sc
  import dpram_sc_pkg::*;
#(
  parameter int unsigned addr_width = DEF_ADDR_WIDTH,
  parameter int unsigned dta_width  = DEF_DTA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [dta_width-1:0]  din,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] rd_addr,
  output logic [dta_width-1:0]  dout
);

  localparam int unsigned depth = 1 << addr_width;

  logic [dta_width-1:0] mem [0:depth-1];

  // Writes are not gated by reset so the array maps onto block RAM unchanged.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= din;
  end

  // Separate read process; non-blocking update gives read-first on address collision.
  always_ff @(posedge clk) begin
    if (!rst)
      dout <= '0;
    else if (rd_en)
      dout <= mem[rd_addr];
  end

endmodule

// File: tb/tb_dpram_sc.sv
// Scoreboard bench for dpram_sc: stimulus queues expected dout values, a monitor checks them.
module tb_dpram_sc;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] din;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic [7:0] dout;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_flag = 1'b0;
  logic chk_pend = 1'b0;
  logic [7:0] model [0:63];

  dpram_sc #(.addr_width(6), .dta_width(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .din    (din),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .dout   (dout)
  );

  always #5 clk = ~clk;

  // An expectation issued before an edge is due on dout after that edge.
  always @(posedge clk) chk_pend <= exp_flag;

  always @(negedge clk) begin
    if (chk_pend) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: dout=%h with no expected value queued", dout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dout !== e.val) begin
          n_bad++;
          $display("FAIL %s: dout=%h required=%h", e.name, dout, e.val);
        end
      end
    end
  end

  // One clock of stimulus; chk queues the dout value required after this edge.
  task automatic drive(input logic r, input logic we, input logic [5:0] wa,
                       input logic [7:0] d, input logic re, input logic [5:0] ra,
                       input logic chk, input logic [7:0] ev, input string nm);
    exp_t e;
    rst = r; wr_en = we; wr_addr = wa; din = d; rd_en = re; rd_addr = ra;
    exp_flag = chk;
    if (chk) begin
      e.name = nm;
      e.val  = ev;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    exp_flag = 1'b0;
  endtask

  initial begin
    int unsigned a;

    // 1. Reset hold with reads requested
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 6'h00, 1'b1, 8'h00, "reset_hold");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 1'b1, 8'h00, "post_reset_idle");

    // 2. Basic write/read at both ends of the address range
    drive(1'b1, 1'b1, 6'h00, 8'hA5, 1'b0, 6'h00, 1'b1, 8'h00, "write_no_read");
    drive(1'b1, 1'b1, 6'h3F, 8'h5A, 1'b0, 6'h00, 1'b0, 8'h00, "");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h00, 1'b1, 8'hA5, "read_addr00");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h3F, 1'b1, 8'h5A, "read_addr3f");

    // 3. Clear sweep, then zigzag 1..64 (0,63,1,62,...), then read back everything
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b1, 6'(i), 8'h00, 1'b0, 6'h00, 1'b0, 8'h00, "");
      model[i] = 8'h00;
    end
    for (int i = 0; i < 64; i++) begin
      a = (i % 2 == 0) ? i / 2 : 63 - i / 2;
      drive(1'b1, 1'b1, 6'(a), 8'(i + 1), 1'b0, 6'h00, 1'b0, 8'h00, "");
      model[a] = 8'(i + 1);
    end
    for (int i = 0; i < 64; i++)
      drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'(i), 1'b1, model[i], "sweep_readback");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h01, 1'b1, 8'h03, "zigzag_addr01");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h3E, 1'b1, 8'h04, "zigzag_addr3e");

    // 4. Read-during-write same address is read-first; different addresses independent
    drive(1'b1, 1'b1, 6'h05, 8'h11, 1'b0, 6'h00, 1'b0, 8'h00, "");
    drive(1'b1, 1'b1, 6'h05, 8'h22, 1'b1, 6'h05, 1'b1, 8'h11, "rdw_old_data");
    drive(1'b1, 1'b1, 6'h06, 8'h77, 1'b1, 6'h05, 1'b1, 8'h22, "rdw_new_data");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h06, 1'b1, 8'h77, "indep_write");

    // 5. rd_en low holds dout while address and array change
    drive(1'b1, 1'b1, 6'h03, 8'h33, 1'b0, 6'h00, 1'b0, 8'h00, "");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h03, 1'b1, 8'h33, "hold_setup");
    drive(1'b1, 1'b1, 6'h03, 8'h44, 1'b0, 6'h03, 1'b1, 8'h33, "hold_same_addr");
    drive(1'b1, 1'b1, 6'h03, 8'h55, 1'b0, 6'h10, 1'b1, 8'h33, "hold_addr_change");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 6'h06, 1'b1, 8'h33, "hold_idle");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h03, 1'b1, 8'h55, "hold_release");

    // 6. Fill, pulse reset, contents survive
    for (int i = 0; i < 64; i++)
      drive(1'b1, 1'b1, 6'(i), 8'(8'hC0 + i), 1'b0, 6'h00, 1'b0, 8'h00, "");
    drive(1'b1, 1'b1, 6'h3F, 8'h5A, 1'b0, 6'h00, 1'b0, 8'h00, "");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h10, 1'b1, 8'hD0, "fill_check");
    drive(1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 6'h3F, 1'b1, 8'h00, "midrun_reset");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h3F, 1'b1, 8'h5A, "after_reset_3f");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h00, 1'b1, 8'hC0, "after_reset_00");

    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 1'b0, 8'h00, "");
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 1'b0, 8'h00, "");
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expected values left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
